// File: rtl/mips_mem_responder_if.sv
// Bundle of core-side request/response signals, SRAM port signals and status
// outputs shared between a MIPS core model and the memory responder.
interface mips_mem_responder_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
);
  logic                  inst_ren;
  logic [31:0]           inst_addr;
  logic [31:0]           inst_data;
  logic                  inst_stall;
  logic                  mem_ren;
  logic                  mem_wen;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_dout;
  logic [31:0]           mem_din;
  logic                  mem_stall;
  logic                  sram_en;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [31:0]           sram_wdata;
  logic [31:0]           sram_rdata;
  logic                  align_err;
  logic                  range_err;
  logic [CNT_WIDTH-1:0]  stall_cnt;

  // Responder side.
  modport slave (
    input  inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout, sram_rdata,
    output inst_data, inst_stall, mem_din, mem_stall, sram_en, sram_we,
           sram_addr, sram_wdata, align_err, range_err, stall_cnt
  );

  // Core / SRAM / observer side.
  modport master (
    output inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout, sram_rdata,
    input  inst_data, inst_stall, mem_din, mem_stall, sram_en, sram_we,
           sram_addr, sram_wdata, align_err, range_err, stall_cnt
  );
endinterface

// File: rtl/mips_mem_responder.sv
// Arbitrates a MIPS core's instruction and data ports onto one single-port
// SRAM. Writes complete in IDLE with no stall; reads take two cycles.
module mips_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips_mem_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    D_RD = 2'd1,
    I_RD = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nx;
  logic                  oor_r;        // pending read targets an out-of-range address
  logic                  oor_nx;
  logic [31:0]           mem_din_r;
  logic [31:0]           inst_data_r;
  logic                  align_err_r;
  logic                  range_err_r;
  logic [CNT_WIDTH-1:0]  stall_cnt_r;

  logic                  sram_en_s;
  logic                  sram_we_s;
  logic [ADDR_WIDTH-1:0] sram_addr_s;
  logic [31:0]           sram_wdata_s;
  logic                  acc_align_s;
  logic                  acc_range_s;
  logic                  inst_stall_s;
  logic                  mem_stall_s;

  logic                  mem_oor_s;
  logic                  inst_oor_s;
  logic                  mem_mis_s;
  logic                  inst_mis_s;

  assign mem_oor_s  = |bus.mem_addr[31:ADDR_WIDTH+2];
  assign inst_oor_s = |bus.inst_addr[31:ADDR_WIDTH+2];
  assign mem_mis_s  = |bus.mem_addr[1:0];
  assign inst_mis_s = |bus.inst_addr[1:0];

  // Arbitration, SRAM command generation and next-state selection.
  always_comb begin
    state_nx     = state_r;
    oor_nx       = oor_r;
    sram_en_s    = 1'b0;
    sram_we_s    = 1'b0;
    sram_addr_s  = {ADDR_WIDTH{1'b0}};
    sram_wdata_s = 32'd0;
    acc_align_s  = 1'b0;
    acc_range_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.mem_wen) begin
          // Out-of-range writes are silently dropped.
          sram_en_s    = ~mem_oor_s;
          sram_we_s    = ~mem_oor_s;
          sram_addr_s  = bus.mem_addr[ADDR_WIDTH+1:2];
          sram_wdata_s = bus.mem_dout;
          acc_align_s  = mem_mis_s;
          acc_range_s  = mem_oor_s;
        end else if (bus.mem_ren) begin
          sram_en_s   = ~mem_oor_s;
          sram_addr_s = bus.mem_addr[ADDR_WIDTH+1:2];
          acc_align_s = mem_mis_s;
          acc_range_s = mem_oor_s;
          oor_nx      = mem_oor_s;
          state_nx    = D_RD;
        end else if (bus.inst_ren) begin
          sram_en_s   = ~inst_oor_s;
          sram_addr_s = bus.inst_addr[ADDR_WIDTH+1:2];
          acc_align_s = inst_mis_s;
          acc_range_s = inst_oor_s;
          oor_nx      = inst_oor_s;
          state_nx    = I_RD;
        end else begin
          state_nx = IDLE;
        end
      end
      D_RD:    state_nx = IDLE;
      I_RD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stalls and SRAM strobes are forced low while reset is held.
  assign inst_stall_s = rst_n & bus.inst_ren & (state_r != I_RD);
  assign mem_stall_s  = rst_n & bus.mem_ren & ~bus.mem_wen & (state_r != D_RD);

  assign bus.sram_en    = rst_n & sram_en_s;
  assign bus.sram_we    = rst_n & sram_we_s;
  assign bus.sram_addr  = sram_addr_s;
  assign bus.sram_wdata = sram_wdata_s;
  assign bus.inst_stall = inst_stall_s;
  assign bus.mem_stall  = mem_stall_s;
  assign bus.inst_data  = inst_data_r;
  assign bus.mem_din    = mem_din_r;
  assign bus.align_err  = align_err_r;
  assign bus.range_err  = range_err_r;
  assign bus.stall_cnt  = stall_cnt_r;

  // FSM state and out-of-range marker for the read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      oor_r   <= 1'b0;
    end else begin
      state_r <= state_nx;
      oor_r   <= oor_nx;
    end
  end

  // Read data capture; each port keeps its last value until its next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_din_r   <= 32'd0;
      inst_data_r <= 32'd0;
    end else if (state_r == D_RD) begin
      mem_din_r <= oor_r ? 32'd0 : bus.sram_rdata;
    end else if (state_r == I_RD) begin
      inst_data_r <= oor_r ? 32'd0 : bus.sram_rdata;
    end else begin
      mem_din_r   <= mem_din_r;
      inst_data_r <= inst_data_r;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err_r <= 1'b0;
      range_err_r <= 1'b0;
    end else begin
      align_err_r <= align_err_r | acc_align_s;
      range_err_r <= range_err_r | acc_range_s;
    end
  end

  // Saturating count of cycles in which either port is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if ((inst_stall_s | mem_stall_s) && (stall_cnt_r != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed + randomized bench for mips_mem_responder with a transaction-level
// reference model (expected memory image, flags and stall count).
module tb_mips_mem_responder;
  localparam int AW   = 10;
  localparam int CW   = 12;            // narrower counter keeps the saturation run short
  localparam int CMAX = (1 << CW) - 1;
  localparam int WORDS = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_mem_responder_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  mips_mem_responder #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // SRAM model: one-cycle read latency, write on enabled strobe.
  logic [31:0] sram_mem [0:WORDS-1];
  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_we) sram_mem[bus.sram_addr] <= bus.sram_wdata;
      else             bus.sram_rdata <= sram_mem[bus.sram_addr];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:WORDS-1];
  int          cnt_exp;
  logic        align_exp, range_exp;
  logic [31:0] din_exp, idata_exp;
  int          tests = 0;
  int          failed = 0;

  function automatic logic is_oor(input logic [31:0] a);
    return a[31:AW+2] != '0;
  endfunction

  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    return a[AW+1:2];
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [AW-1:0] w;
    w = AW'($urandom_range(0, WORDS-1));
    return {20'd0, w, 2'b00};
  endfunction

  function automatic logic [31:0] read_exp(input logic [31:0] a);
    return is_oor(a) ? 32'd0 : ref_mem[widx(a)];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add_stall(input int n);
    cnt_exp = (cnt_exp + n > CMAX) ? CMAX : cnt_exp + n;
  endtask

  task automatic note_access(input logic [31:0] a);
    align_exp = align_exp | (a[1:0] != 2'b00);
    range_exp = range_exp | is_oor(a);
  endtask

  task automatic check_status(input string tag);
    check({tag, "/align"},   32'(bus.align_err), 32'(align_exp));
    check({tag, "/range"},   32'(bus.range_err), 32'(range_exp));
    check({tag, "/cnt"},     32'(bus.stall_cnt), 32'(cnt_exp));
    check({tag, "/mem_din"}, bus.mem_din, din_exp);
    check({tag, "/inst"},    bus.inst_data, idata_exp);
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bus.mem_wen = 1'b1; bus.mem_addr = a; bus.mem_dout = d;
    @(negedge clk);
    check("wr/stall", 32'(bus.mem_stall), 32'd0);
    check("wr/en", 32'(bus.sram_en), 32'(!is_oor(a)));
    if (!is_oor(a)) begin
      check("wr/we", 32'(bus.sram_we), 32'd1);
      check("wr/addr", 32'(bus.sram_addr), 32'(widx(a)));
      check("wr/data", bus.sram_wdata, d);
    end
    @(posedge clk); #1;
    bus.mem_wen = 1'b0;
    if (!is_oor(a)) ref_mem[widx(a)] = d;
    note_access(a);
    check_status("wr");
  endtask

  task automatic do_read(input logic [31:0] a);
    bus.mem_ren = 1'b1; bus.mem_addr = a;
    @(negedge clk);
    check("rd/stall1", 32'(bus.mem_stall), 32'd1);
    check("rd/en", 32'(bus.sram_en), 32'(!is_oor(a)));
    check("rd/we", 32'(bus.sram_we), 32'd0);
    @(negedge clk);
    check("rd/stall0", 32'(bus.mem_stall), 32'd0);
    @(posedge clk); #1;
    bus.mem_ren = 1'b0;
    din_exp = read_exp(a);
    note_access(a);
    add_stall(1);
    check_status("rd");
  endtask

  task automatic do_iread(input logic [31:0] a);
    bus.inst_ren = 1'b1; bus.inst_addr = a;
    @(negedge clk);
    check("ir/stall1", 32'(bus.inst_stall), 32'd1);
    check("ir/en", 32'(bus.sram_en), 32'(!is_oor(a)));
    @(negedge clk);
    check("ir/stall0", 32'(bus.inst_stall), 32'd0);
    @(posedge clk); #1;
    bus.inst_ren = 1'b0;
    idata_exp = read_exp(a);
    note_access(a);
    add_stall(1);
    check_status("ir");
  endtask

  // Data and instruction read requested together: data first.
  task automatic do_conflict(input logic [31:0] ma, input logic [31:0] ia);
    bus.mem_ren = 1'b1; bus.mem_addr = ma;
    bus.inst_ren = 1'b1; bus.inst_addr = ia;
    @(negedge clk);
    check("cf/mstall1", 32'(bus.mem_stall), 32'd1);
    check("cf/istall_a", 32'(bus.inst_stall), 32'd1);
    @(negedge clk);
    check("cf/mstall0", 32'(bus.mem_stall), 32'd0);
    check("cf/istall_b", 32'(bus.inst_stall), 32'd1);
    @(posedge clk); #1;
    bus.mem_ren = 1'b0;
    din_exp = read_exp(ma);
    check("cf/mem_din", bus.mem_din, din_exp);
    @(negedge clk);
    check("cf/istall_c", 32'(bus.inst_stall), 32'd1);
    @(negedge clk);
    check("cf/istall0", 32'(bus.inst_stall), 32'd0);
    @(posedge clk); #1;
    bus.inst_ren = 1'b0;
    idata_exp = read_exp(ia);
    note_access(ma);
    note_access(ia);
    add_stall(3);
    check_status("cf");
  endtask

  // Write issued while an instruction read waits: instruction delayed 1 cycle.
  task automatic do_wr_iread(input logic [31:0] wa, input logic [31:0] d, input logic [31:0] ia);
    bus.mem_wen = 1'b1; bus.mem_addr = wa; bus.mem_dout = d;
    bus.inst_ren = 1'b1; bus.inst_addr = ia;
    @(negedge clk);
    check("wi/istall_a", 32'(bus.inst_stall), 32'd1);
    check("wi/mstall", 32'(bus.mem_stall), 32'd0);
    check("wi/we", 32'(bus.sram_we), 32'd1);
    @(posedge clk); #1;
    bus.mem_wen = 1'b0;
    ref_mem[widx(wa)] = d;
    @(negedge clk);
    check("wi/istall_b", 32'(bus.inst_stall), 32'd1);
    @(negedge clk);
    check("wi/istall0", 32'(bus.inst_stall), 32'd0);
    @(posedge clk); #1;
    bus.inst_ren = 1'b0;
    idata_exp = read_exp(ia);
    note_access(wa);
    note_access(ia);
    add_stall(2);
    check_status("wi");
  endtask

  initial begin
    logic [31:0] a, b;
    int op;
    for (int i = 0; i < WORDS; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    sram_mem[4] = 32'h2010_0001;
    ref_mem[4]  = 32'h2010_0001;
    cnt_exp = 0; align_exp = 1'b0; range_exp = 1'b0;
    din_exp = 32'd0; idata_exp = 32'd0;

    // Reset: requests present but strobes and stalls must stay low.
    rst_n = 1'b0;
    bus.inst_ren = 1'b1; bus.inst_addr = 32'h10;
    bus.mem_ren = 1'b1; bus.mem_wen = 1'b0; bus.mem_addr = 32'h40; bus.mem_dout = 32'd0;
    #12;
    check("rst/en", 32'(bus.sram_en), 32'd0);
    check("rst/we", 32'(bus.sram_we), 32'd0);
    check("rst/istall", 32'(bus.inst_stall), 32'd0);
    check("rst/mstall", 32'(bus.mem_stall), 32'd0);
    check_status("rst");
    bus.inst_ren = 1'b0; bus.mem_ren = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed scenarios.
    do_iread(32'h0000_0010);
    check("req039", bus.inst_data, 32'h2010_0001);
    do_write(32'h0000_0040, 32'hDEAD_BEEF);
    do_read(32'h0000_0040);
    check("req040", bus.mem_din, 32'hDEAD_BEEF);
    do_conflict(rnd_addr(), rnd_addr());

    // Randomized aligned, in-range traffic.
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 4));
      a = rnd_addr();
      b = rnd_addr();
      case (op)
        0:       do_write(a, $urandom);
        1:       do_read(a);
        2:       do_iread(a);
        3:       do_conflict(a, b);
        default: do_wr_iread(a, $urandom, b);
      endcase
    end

    // Misaligned in-range write then readback through the word address.
    do_write(32'h0000_0103, 32'h1234_5678);
    do_read(32'h0000_0100);
    check("mis/readback", bus.mem_din, 32'h1234_5678);

    // Out-of-range misaligned read; out-of-range write must be dropped.
    do_read(32'h0000_1003);
    check("req042/din", bus.mem_din, 32'd0);
    do_write(32'h0001_0040, 32'hBAD0_BAD0);
    do_read(32'h0000_0040);
    do_iread(32'h0000_2000);

    // Long stall: instruction read starved by back-to-back writes.
    bus.inst_ren = 1'b1; b = rnd_addr(); bus.inst_addr = b;
    for (int i = 0; i < CMAX + 100; i++) begin
      a = rnd_addr();
      bus.mem_wen = 1'b1; bus.mem_addr = a; bus.mem_dout = $urandom;
      @(posedge clk); #1;
      ref_mem[widx(a)] = bus.mem_dout;
    end
    bus.mem_wen = 1'b0;
    add_stall(CMAX + 100);
    check("sat/cnt_a", 32'(bus.stall_cnt), 32'(CMAX));
    @(negedge clk);
    check("sat/istall1", 32'(bus.inst_stall), 32'd1);
    @(negedge clk);
    check("sat/istall0", 32'(bus.inst_stall), 32'd0);
    @(posedge clk); #1;
    bus.inst_ren = 1'b0;
    idata_exp = read_exp(b);
    add_stall(1);
    check_status("sat");
    check("sat/cnt_b", 32'(bus.stall_cnt), 32'(CMAX));

    // Reset asserted while a data read sits in D_RD.
    do_write(32'h0000_0080, 32'hA5A5_5A5A);
    do_read(32'h0000_0080);
    bus.mem_ren = 1'b1; bus.mem_addr = 32'h80;
    bus.inst_ren = 1'b1; bus.inst_addr = 32'h10;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    cnt_exp = 0; align_exp = 1'b0; range_exp = 1'b0;
    din_exp = 32'd0; idata_exp = 32'd0;
    check("rdrst/en", 32'(bus.sram_en), 32'd0);
    check("rdrst/mstall", 32'(bus.mem_stall), 32'd0);
    check("rdrst/istall", 32'(bus.inst_stall), 32'd0);
    check_status("rdrst");
    bus.mem_ren = 1'b0; bus.inst_ren = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_iread(32'h0000_0010);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
